hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that generates the stall and synchronous flush controls consumed by the PC, IF/ID and ID/EX pipeline registers. It drives the active-high synchronous `flush` input of the EX-stage control register, inserting bubbles for load-use hazards, taken branches and multi-cycle multiply/divide operations. It also tracks multiply/divide busy time with a down-counter and keeps a saturating bubble counter for performance debug.

## Interface
- MD_CYCLES, 4, multiply/divide latency in cycles; legal range 2..32
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  5  destination register of the EX load
- branch_taken  in  1  branch/jump resolved taken in EX
- md_start  in  1  EX instruction is a multiply/divide
- pc_stall  out  1  hold the PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID (synchronous, active high)
- idex_flush  out  1  zero ID/EX control, i.e. insert a bubble
- md_busy  out  1  multiply/divide in progress
- md_done  out  1  one-cycle pulse in the final busy cycle
- bubble_cnt  out  16  number of cycles with idex_flush high, saturating

## Operation
- State register: RUN, MD_BUSY. The 5-bit down-counter is `cnt`.
- Control outputs are combinational from state, `cnt` and the current inputs. While rst_n=0, every control output is forced to 0.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_memread=1
  - ex_rt≠0
  - (id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt)
- In RUN, evaluate the cases in this priority order:
  1. branch_taken=1: ifid_flush=1 and idex_flush=1; no stall. Any coincident md_start or lu is ignored.
  2. md_start=1: pc_stall=1, ifid_stall=1, idex_flush=1. Next state is MD_BUSY with cnt←MD_CYCLES−2.
  3. lu=1: pc_stall=1, ifid_stall=1, idex_flush=1. State stays RUN.
  4. Otherwise all control outputs are 0.
- In MD_BUSY:
  - pc_stall=1, ifid_stall=1, idex_flush=1, md_busy=1.
  - branch_taken, md_start and lu are ignored.
  - If cnt==0: md_done=1 and next state is RUN. Otherwise cnt←cnt−1.
- Total stall for one md op is MD_CYCLES cycles: the start cycle plus MD_CYCLES−1 busy cycles.
- bubble_cnt increments by 1 on every rising edge where idex_flush=1. It holds at 0xFFFF and never wraps.
- Whenever both are asserted, ifid_stall has priority over the IF/ID write; ifid_flush and ifid_stall are never high together.

## Timing
- Reset values: state=RUN, cnt=0, bubble_cnt=0, and all control outputs 0.
- Reset mid-MD_BUSY: the next cycle after rst_n rises is RUN with no md_done. The aborted op is not resumed.
- Zero latency from inputs to stall/flush outputs, which must settle within the cycle. Flush takes effect at the next clk edge in the destination registers.
- lu causes exactly one bubble. If the hazard persists after the stall, it is re-evaluated each cycle, but a load in EX becomes a bubble, so lu cannot repeat.
- md_done is high only in the last of the MD_CYCLES stall cycles. md_busy is high in cycles 2..MD_CYCLES.
- For MD_CYCLES=2: the start cycle loads cnt=0, the next cycle asserts md_done, and the following cycle is RUN.

## Test plan
- Reset: hold rst_n=0 with branch_taken=1 and md_start=1. Required: all controls 0 and bubble_cnt=0. Release rst_n and idle for 3 cycles: all controls stay 0.
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle. Required: pc_stall=ifid_stall=idex_flush=1 for exactly that cycle, bubble_cnt=1. Repeat with ex_rt=0: no stall.
- Branch priority: branch_taken=1 with lu conditions true. Required: ifid_flush=idex_flush=1, pc_stall=0, ifid_stall=0.
- Multiply/divide with MD_CYCLES=4: pulse md_start for one cycle. Required: stall and idex_flush high for 4 cycles, md_busy high in cycles 2–4, md_done high only in cycle 4, RUN in cycle 5, bubble_cnt=4. Assert branch_taken in cycle 3: no effect.
- Reset mid-op: assert rst_n=0 in cycle 2 of MD_BUSY. Required: controls drop immediately, no md_done, and bubble_cnt=0 after release.
- Saturation: force 70000 consecutive lu cycles. Required: bubble_cnt=0xFFFF and it stays there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch and mul/div stall/flush control.
// Also counts inserted bubbles (saturating) for performance debug.
module hazard_ctrl #(
  parameter int MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        md_start,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] bubble_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] bub_q;
  logic        lu;
  logic        stall_c, ifl_c, xfl_c;
  logic        busy_c, done_c;

  assign lu = ex_memread && (ex_rt != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rt)) ||
               (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    ifl_c   = 1'b0;
    xfl_c   = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          ifl_c = 1'b1;
          xfl_c = 1'b1;
        end else if (md_start) begin
          stall_c = 1'b1;
          xfl_c   = 1'b1;
          state_d = MD_BUSY;
          cnt_d   = 5'(MD_CYCLES - 2);
        end else if (lu) begin
          stall_c = 1'b1;
          xfl_c   = 1'b1;
        end
      end
      MD_BUSY: begin
        stall_c = 1'b1;
        xfl_c   = 1'b1;
        busy_c  = 1'b1;
        if (cnt_q == 5'd0) begin
          done_c  = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Controls are gated by rst_n so they drop the instant reset asserts
  assign pc_stall   = rst_n & stall_c;
  assign ifid_stall = rst_n & stall_c;
  assign ifid_flush = rst_n & ifl_c;
  assign idex_flush = rst_n & xfl_c;
  assign md_busy    = rst_n & busy_c;
  assign md_done    = rst_n & done_c;
  assign bubble_cnt = bub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 5'd0;
      bub_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (xfl_c && (bub_q != 16'hFFFF))
        bub_q <= bub_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-level reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_memread;
  logic        branch_taken, md_start;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
  logic        md_busy, md_done;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];
  string       tag_q[$];

  int md_left;
  int bubbles;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_CYCLES(MD)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .md_start(md_start),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .md_busy(md_busy), .md_done(md_done),
    .bubble_cnt(bubble_cnt)
  );

  // Model: md_left = remaining busy cycles after the start cycle.
  task automatic cyc(input string tag, input bit rn, input bit br,
                     input bit ms, input bit mr, input int xr,
                     input int rs, input int rt, input bit urs,
                     input bit urt);
    bit st, ifl, xfl, bsy, dn, hz;
    @(posedge clk);
    #1;
    rst_n = rn; branch_taken = br; md_start = ms;
    ex_memread = mr; ex_rt = 5'(xr);
    id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rs = urs; id_uses_rt = urt;
    st = 0; ifl = 0; xfl = 0; bsy = 0; dn = 0;
    hz = mr && xr != 0 && ((urs && rs == xr) || (urt && rt == xr));
    if (!rn) begin
      md_left = 0;
      bubbles = 0;
    end else if (md_left > 0) begin
      st = 1; xfl = 1; bsy = 1;
      dn = (md_left == 1);
    end else if (br) begin
      ifl = 1; xfl = 1;
    end else if (ms || hz) begin
      st = 1; xfl = 1;
    end
    exp_q.push_back({st, st, ifl, xfl, bsy, dn, 16'(bubbles)});
    tag_q.push_back(tag);
    if (rn) begin
      if (md_left > 0) md_left--;
      else if (!br && ms) md_left = MD - 1;
      if (xfl && bubbles < 65535) bubbles++;
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {pc_stall, ifid_stall, ifid_flush, idex_flush,
           md_busy, md_done, bubble_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got ctl=%b bub=%h expected ctl=%b bub=%h",
                 t, a[21:16], a[15:0], e[21:16], e[15:0]);
      end
    end
  end

  initial begin
    md_left = 0; bubbles = 0;
    rst_n = 0; branch_taken = 1; md_start = 1;
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    cyc("reset", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("reset", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle("post_reset", 3);

    cyc("lu", 1, 0, 0, 1, 5, 5, 0, 1, 0);
    idle("lu_after", 1);
    cyc("lu_rt", 1, 0, 0, 1, 7, 1, 7, 0, 1);
    cyc("lu_r0", 1, 0, 0, 1, 0, 0, 0, 1, 1);
    cyc("lu_unused", 1, 0, 0, 1, 5, 5, 5, 0, 0);
    idle("lu_after", 1);

    cyc("br_prio", 1, 1, 0, 1, 5, 5, 0, 1, 0);
    cyc("br_md", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle("br_after", 1);

    cyc("md_c1", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("md_c2", 1, 0, 0, 1, 3, 3, 0, 1, 0);
    cyc("md_c3", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("md_c4", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("md_c5", 2);

    cyc("mdrst_c1", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("mdrst_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mdrst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("mdrst_after", 5);

    for (int i = 0; i < 3000; i++) begin
      bit rn;
      rn = ($urandom_range(0, 99) != 0);
      cyc("random", rn,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    cyc("sat_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++)
      cyc("sat", 1, 0, 0, 1, 9, 9, 9, 1, 1);
    idle("sat_hold", 4);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
